// File: rtl/rv32i_pkg.sv
// Shared constants for the rv32i core: default datapath geometry and the
// architectural zero register index.
package rv32i_pkg;

    localparam int unsigned RV_XLEN  = 32;
    localparam int unsigned RV_NREGS = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue and
// cleared on write-back, plus detection of a WAW clash at issue.
module rf_scoreboard
    import rv32i_pkg::*;
#(
    parameter int unsigned NREGS = RV_NREGS,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Issue,
    input  logic [AW-1:0]    IssueRd,
    input  logic             RegWrite,
    input  logic [AW-1:0]    rd,
    input  logic             Stall,
    output logic [NREGS-1:0] Busy,
    output logic             waw
);

    localparam logic [NREGS-1:0] ONE_HOT_0 = {{(NREGS-1){1'b0}}, 1'b1};

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_next_s;
    logic [NREGS-1:0] set_mask_s;
    logic [NREGS-1:0] clr_mask_s;
    logic             wb_nz_s;
    logic             issue_nz_s;

    // Hazard qualification and set/clear masks; set is applied after clear
    // so a same-cycle re-issue of the retiring register keeps it busy.
    always_comb begin
        wb_nz_s     = RegWrite && (rd != AW'(REG_ZERO));
        issue_nz_s  = Issue && (IssueRd != AW'(REG_ZERO));
        waw         = issue_nz_s && busy_r[IssueRd] && !(wb_nz_s && (rd == IssueRd));
        clr_mask_s  = wb_nz_s ? (ONE_HOT_0 << rd) : {NREGS{1'b0}};
        set_mask_s  = (issue_nz_s && !Stall) ? (ONE_HOT_0 << IssueRd) : {NREGS{1'b0}};
        busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~ONE_HOT_0;
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    assign Busy = busy_r;

endmodule

// File: rtl/regfile_sb.sv
// Register file with x0 hardwired to zero, NRP combinational read ports with
// optional write-back forwarding, and scoreboard-driven RAW/WAW stall.
module regfile_sb
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN   = RV_XLEN,
    parameter int unsigned NREGS  = RV_NREGS,
    parameter int unsigned NRP    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RegWrite,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     Result,
    input  logic [NRP*AW-1:0]   rs,
    input  logic [NRP-1:0]      RsEn,
    output logic [NRP*XLEN-1:0] RD,
    input  logic                Issue,
    input  logic [AW-1:0]       IssueRd,
    output logic                Stall,
    output logic [NREGS-1:0]    Busy
);

    logic [XLEN-1:0]  mem_r [NREGS];
    logic [NREGS-1:0] busy_s;
    logic [NRP-1:0]   raw_s;
    logic [AW-1:0]    rs_p_s;
    logic             hit_s;
    logic             wb_nz_s;
    logic             waw_s;

    assign wb_nz_s = RegWrite && (rd != AW'(REG_ZERO));

    // Storage array; reset clears every entry so reads return zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_nz_s) begin
            mem_r[rd] <= Result;
        end else begin
            mem_r[rd] <= mem_r[rd];
        end
    end

    // Read muxes with forwarding and per-port RAW qualification.
    always_comb begin
        RD     = {(NRP*XLEN){1'b0}};
        raw_s  = {NRP{1'b0}};
        rs_p_s = {AW{1'b0}};
        hit_s  = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            rs_p_s = rs[p*AW +: AW];
            hit_s  = wb_nz_s && (rd == rs_p_s);
            if (rs_p_s == AW'(REG_ZERO)) begin
                RD[p*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if ((BYPASS != 0) && hit_s && !rst) begin
                RD[p*XLEN +: XLEN] = Result;
            end else begin
                RD[p*XLEN +: XLEN] = mem_r[rs_p_s];
            end
            raw_s[p] = RsEn[p] && busy_s[rs_p_s] && !((BYPASS != 0) && hit_s);
        end
        Stall = (|raw_s) || waw_s;
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .Issue    (Issue),
        .IssueRd  (IssueRd),
        .RegWrite (RegWrite),
        .rd       (rd),
        .Stall    (Stall),
        .Busy     (busy_s),
        .waw      (waw_s)
    );

    assign Busy = busy_s;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass and non-bypass instances share one
// stimulus stream; two NRP=3 instances (32x32 and 16x64) run a read-back sweep.
module tb_regfile_sb;

    logic clk;
    logic rst;

    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] Result;
    logic [9:0]  rs;
    logic [1:0]  RsEn;
    logic        Issue;
    logic [4:0]  IssueRd;
    logic [63:0] rd_a, rd_b;
    logic        stall_a, stall_b;
    logic [31:0] busy_a, busy_b;

    logic        s_we;
    logic [4:0]  s_rd;
    logic [31:0] s_res;
    logic [14:0] s_rs;
    logic [95:0] s_out;
    logic        s_stall;
    logic [31:0] s_busy;

    logic        w_we;
    logic [3:0]  w_rd;
    logic [63:0] w_res;
    logic [11:0] w_rs;
    logic [191:0] w_out;
    logic        w_stall;
    logic [15:0] w_busy;

    logic [31:0] s_exp [32];
    logic [63:0] w_exp [16];

    int checks = 0;
    int errors = 0;

    regfile_sb #(.XLEN(32), .NREGS(32), .NRP(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .rd(rd), .Result(Result),
        .rs(rs), .RsEn(RsEn), .RD(rd_a), .Issue(Issue), .IssueRd(IssueRd),
        .Stall(stall_a), .Busy(busy_a)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NRP(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .rd(rd), .Result(Result),
        .rs(rs), .RsEn(RsEn), .RD(rd_b), .Issue(Issue), .IssueRd(IssueRd),
        .Stall(stall_b), .Busy(busy_b)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NRP(3), .BYPASS(1)) dut_s (
        .clk(clk), .rst(rst), .RegWrite(s_we), .rd(s_rd), .Result(s_res),
        .rs(s_rs), .RsEn(3'b000), .RD(s_out), .Issue(1'b0), .IssueRd(5'd0),
        .Stall(s_stall), .Busy(s_busy)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NRP(3), .BYPASS(1)) dut_w (
        .clk(clk), .rst(rst), .RegWrite(w_we), .rd(w_rd), .Result(w_res),
        .rs(w_rs), .RsEn(3'b000), .RD(w_out), .Issue(1'b0), .IssueRd(4'd0),
        .Stall(w_stall), .Busy(w_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        RegWrite = 1'b1; rd = 5'd7; Result = 32'h0000_0055;
        rs = {5'd7, 5'd7}; RsEn = 2'b11; Issue = 1'b1; IssueRd = 5'd4;
        s_we = 1'b0; s_rd = 5'd0; s_res = 32'd0; s_rs = 15'd0;
        w_we = 1'b0; w_rd = 4'd0; w_res = 64'd0; w_rs = 12'd0;

        // Reset: write/issue ignored, bypass gated, outputs zero
        @(negedge clk); #1;
        check("rst_rd", {32'd0, rd_a}, 64'd0);
        check("rst_stall", {63'd0, stall_a}, 64'd0);
        check("rst_busy", {32'd0, busy_a}, 64'd0);

        @(negedge clk);
        rst = 1'b0; RegWrite = 1'b0; Issue = 1'b0; RsEn = 2'b00; rs = 10'd0;
        #1;
        check("rel_busy", {32'd0, busy_a}, 64'd0);
        check("rel_x7", {32'd0, rd_b[31:0]}, 64'd0);

        // Write x5 then async reset mid-cycle
        @(negedge clk);
        RegWrite = 1'b1; rd = 5'd5; Result = 32'hDEAD_BEEF;
        @(negedge clk);
        RegWrite = 1'b0; rs = {5'd0, 5'd5};
        #1;
        check("x5_a", {32'd0, rd_a[31:0]}, 64'h0000_0000_DEAD_BEEF);
        check("x5_b", {32'd0, rd_b[31:0]}, 64'h0000_0000_DEAD_BEEF);
        rst = 1'b1; #1;
        check("midrst_x5", {32'd0, rd_a[31:0]}, 64'd0);
        check("midrst_busy", {32'd0, busy_a}, 64'd0);
        rst = 1'b0; #1;
        check("postrst_x5", {32'd0, rd_b[31:0]}, 64'd0);

        // x0 immutability
        @(negedge clk);
        RegWrite = 1'b1; rd = 5'd0; Result = 32'hFFFF_FFFF;
        rs = {5'd0, 5'd0}; RsEn = 2'b11; Issue = 1'b1; IssueRd = 5'd0;
        #1;
        check("x0_rd_a", rd_a, 64'd0);
        check("x0_stall", {63'd0, stall_a}, 64'd0);
        @(negedge clk);
        RegWrite = 1'b0; Issue = 1'b0;
        #1;
        check("x0_busy", {32'd0, busy_a}, 64'd0);
        check("x0_rd_b", rd_b, 64'd0);

        // Bypass vs. no bypass
        RsEn = 2'b00;
        RegWrite = 1'b1; rd = 5'd7; Result = 32'hAAAA_0000;
        @(negedge clk);
        Result = 32'h1234_5678; rs = {5'd7, 5'd7};
        #1;
        check("byp_a0", {32'd0, rd_a[31:0]}, 64'h0000_0000_1234_5678);
        check("byp_a1", {32'd0, rd_a[63:32]}, 64'h0000_0000_1234_5678);
        check("nobyp_b0", {32'd0, rd_b[31:0]}, 64'h0000_0000_AAAA_0000);
        @(negedge clk);
        RegWrite = 1'b0;
        #1;
        check("nobyp_b0_next", {32'd0, rd_b[31:0]}, 64'h0000_0000_1234_5678);

        // RAW on port 1
        @(negedge clk);
        Issue = 1'b1; IssueRd = 5'd3; rs = {5'd3, 5'd0}; RsEn = 2'b10;
        #1;
        check("raw_issue_stall", {63'd0, stall_a}, 64'd0);
        @(negedge clk);
        Issue = 1'b0;
        #1;
        check("raw_busy", {32'd0, busy_a}, 64'h8);
        check("raw_stall_a", {63'd0, stall_a}, 64'd1);
        check("raw_stall_b", {63'd0, stall_b}, 64'd1);
        @(negedge clk); #1;
        check("raw_hold", {63'd0, stall_a}, 64'd1);
        RsEn = 2'b00; #1;
        check("raw_unused", {62'd0, stall_a, stall_b}, 64'd0);
        RsEn = 2'b10; RegWrite = 1'b1; rd = 5'd3; Result = 32'h0000_0033;
        #1;
        check("raw_wb_stall_a", {63'd0, stall_a}, 64'd0);
        check("raw_wb_stall_b", {63'd0, stall_b}, 64'd1);
        check("raw_wb_rd1", {32'd0, rd_a[63:32]}, 64'h33);
        @(negedge clk);
        RegWrite = 1'b0;
        #1;
        check("raw_clr_busy", {32'd0, busy_a}, 64'd0);
        check("raw_clr_stall", {62'd0, stall_a, stall_b}, 64'd0);

        // RAW on port 0
        RsEn = 2'b01; rs = {5'd0, 5'd3};
        Issue = 1'b1; IssueRd = 5'd3;
        @(negedge clk);
        Issue = 1'b0; #1;
        check("raw_p0", {63'd0, stall_a}, 64'd1);
        RegWrite = 1'b1; rd = 5'd3; Result = 32'h0000_0044;
        @(negedge clk);
        RegWrite = 1'b0; RsEn = 2'b00; #1;
        check("raw_p0_clr", {32'd0, busy_a}, 64'd0);

        // WAW and simultaneous events on x9
        Issue = 1'b1; IssueRd = 5'd9;
        @(negedge clk); #1;
        check("waw_busy", {32'd0, busy_a}, 64'h200);
        check("waw_stall", {63'd0, stall_a}, 64'd1);
        @(negedge clk); #1;
        check("waw_busy_hold", {32'd0, busy_a}, 64'h200);
        IssueRd = 5'd10; rs = {5'd9, 5'd0}; RsEn = 2'b10;
        @(negedge clk); #1;
        check("stall_no_issue", {32'd0, busy_a}, 64'h200);
        RsEn = 2'b00; IssueRd = 5'd9;
        RegWrite = 1'b1; rd = 5'd9; Result = 32'h0000_0099;
        #1;
        check("sim_stall", {62'd0, stall_a, stall_b}, 64'd0);
        @(negedge clk);
        Issue = 1'b0; #1;
        check("sim_set_wins", {32'd0, busy_a}, 64'h200);
        @(negedge clk);
        RegWrite = 1'b0; #1;
        check("x9_clr", {32'd0, busy_a}, 64'd0);

        // Write-back to a non-busy register
        RegWrite = 1'b1; rd = 5'd12; Result = 32'hC0FF_EE00;
        @(negedge clk);
        RegWrite = 1'b0; rs = {5'd9, 5'd12};
        #1;
        check("nb_busy", {32'd0, busy_a}, 64'd0);
        check("nb_rd0", {32'd0, rd_b[31:0]}, 64'h0000_0000_C0FF_EE00);
        check("nb_rd1", {32'd0, rd_b[63:32]}, 64'h99);

        // Sweep: fill every register, then read each value on every port
        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            logic [63:0] v64;
            v = $urandom;
            v64 = {$urandom, $urandom};
            s_we = 1'b1; s_rd = 5'(i); s_res = v;
            s_exp[i] = (i == 0) ? 32'd0 : v;
            if (i < 16) begin
                w_we = 1'b1; w_rd = 4'(i); w_res = v64;
                w_exp[i] = (i == 0) ? 64'd0 : v64;
            end else begin
                w_we = 1'b0;
            end
            @(negedge clk);
        end
        s_we = 1'b0; w_we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            s_rs = {5'(i + 2), 5'(i + 1), 5'(i)};
            w_rs = {4'(i + 2), 4'(i + 1), 4'(i)};
            #1;
            for (int p = 0; p < 3; p++) begin
                check($sformatf("sw32_r%0d_p%0d", (i + p) % 32, p),
                      {32'd0, s_out[p*32 +: 32]}, {32'd0, s_exp[(i + p) % 32]});
                if (i < 16) begin
                    check($sformatf("sw64_r%0d_p%0d", (i + p) % 16, p),
                          w_out[p*64 +: 64], w_exp[(i + p) % 16]);
                end
            end
            @(negedge clk);
        end
        check("sw_busy", {w_busy, s_busy, 14'd0, w_stall, s_stall}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the core's register file: NREGS x XLEN storage with x0 hardwired to zero, NRP combinational read ports, an optional write-to-read bypass, and a per-register pending-write scoreboard. It sits between decode/issue and write-back in the pipelined rv32i core. The decode stage reads operands from it, and it raises `Stall` on RAW or WAW hazards against in-flight writes.

## Interface
- `XLEN`, 32, data width.
- `NREGS`, 32, register count; power of two, at least 2; `AW = $clog2(NREGS)`.
- `NRP`, 2, number of read ports, at least 1.
- `BYPASS`, 1, 1 forwards the same-cycle write to readers; 0 disables forwarding.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `RegWrite`  in  1  write-back enable.
- `rd`  in  AW  write-back register index.
- `Result`  in  XLEN  write-back data.
- `rs`  in  NRP*AW  read indices; port p is `rs[p*AW +: AW]`.
- `RsEn`  in  NRP  port p's operand is actually used (hazard qualification).
- `RD`  out  NRP*XLEN  read data; port p is `RD[p*XLEN +: XLEN]`.
- `Issue`  in  1  an instruction with a destination is issuing this cycle.
- `IssueRd`  in  AW  destination of the issuing instruction.
- `Stall`  out  1  hazard; the issuer must hold the instruction.
- `Busy`  out  NREGS  scoreboard bits; bit 0 is always 0.

## Operation
- Write:
  - At the rising `clk` edge with `RegWrite=1` and `rd!=0`, `mem[rd] <= Result`.
  - Writes to x0 are discarded.
  - Writes are ignored while `rst=1`.
- Read port p, combinational:
  - If `rs_p==0`, RD_p is 0.
  - Otherwise, if `BYPASS=1`, `RegWrite=1`, `rd==rs_p`, `rd!=0` and `rst=0`, RD_p is `Result`.
  - Otherwise, RD_p is `mem[rs_p]`.
- Write-back match `wb_hit(r)`: `RegWrite & (rd==r) & (r!=0)`.
- RAW hazard for port p: `RsEn_p & Busy[rs_p]`. When `BYPASS=1`, it is suppressed if `wb_hit(rs_p)`.
- WAW hazard: `Issue & (IssueRd!=0) & Busy[IssueRd] & !wb_hit(IssueRd)`.
- `Stall` is the OR of all RAW hazards and the WAW hazard.
- Scoreboard update at each rising edge:
  - If `wb_hit(r)`, clear `Busy[r]`.
  - If `Issue & !Stall & IssueRd!=0`, set `Busy[IssueRd]`.
  - When both target the same register in the same cycle, set wins (the new producer).
  - While `Stall=1`, `Issue` has no effect on `Busy`.
- A write-back to a register that is not busy is legal: data is written and `Busy` is unchanged.
- Reset (async, `rst=1`):
  - All `mem` entries become 0 and all `Busy` bits become 0, immediately.
  - Outputs during and after reset: `RD` all 0, `Stall=0`, `Busy=0`.

## Timing
- Write latency: data is visible via the array from the cycle after the edge. With `BYPASS=1`, it is also visible in the same cycle combinationally.
- `Busy` set or clear is visible the cycle after the edge that performs it.
- `Stall` is combinational from inputs and `Busy`; there is no registered delay.
- An issue at edge N followed by a dependent read in cycle N+1 gives `Stall=1` until the write-back cycle. With bypass, the stall drops in the write-back cycle itself.
- Reset asserted mid-operation overrides any write or issue in the same cycle. Release takes effect at the first edge with `rst=0`.

## Structure
- Shared package `rv32i_pkg` holds:
  - defaults `XLEN=32` and `NREGS=32`;
  - `REG_AW=5`;
  - constant `REG_ZERO=0`.
- Sub-module `rf_scoreboard` holds the `Busy` vector, the set/clear priority logic and WAW detection. It takes `clk`, `rst`, `Issue`, `IssueRd`, `RegWrite`, `rd` and `Stall`, and outputs `Busy`.
- `regfile_sb` contains the storage array, the NRP read muxes with bypass, and the RAW/Stall combine.

## Test plan
- **Reset clear:** write 0xDEADBEEF to x5, then pulse `rst` mid-cycle -> `RD` for x5 reads 0 immediately and `Busy=0`.
- **x0 immutability:** `RegWrite=1`, `rd=0`, `Result=0xFFFFFFFF` -> reading x0 on every port gives 0. `Issue` to x0 leaves `Busy[0]=0` and `Stall=0`.
- **Bypass:** `BYPASS=1`, `RegWrite=1`, `rd=7`, `Result=0x12345678`, `rs0=7` -> RD0=0x12345678 in the same cycle. With `BYPASS=0`, RD0 shows the old value until the next cycle.
- **RAW stall:**
  - Issue `IssueRd=3` at edge N, then `rs1=3` with `RsEn=2'b10` -> `Stall=1` until write-back of x3.
  - With `RsEn=2'b00` -> `Stall=0`.
- **WAW and simultaneous events:**
  - With x9 busy, `Issue` to x9 -> `Stall=1` and `Busy[9]` is unchanged.
  - Write-back of x9 plus `Issue` of x9 in the same cycle -> `Stall=0` and `Busy[9]=1` afterwards.
- **Sweep:** with `NRP=3`, write `$random` to all 32 registers -> each port reads back every value. Then run with `NREGS=16`, `XLEN=64` on the same sequence.
